dispatch_router: RTL

Parametrised N-channel dispatch stage between rename and the reservation stations. It holds one renamed packet in a holding register and steers it to exactly one of NUM_FU reservation-station channels. Each dispatch is paired atomically with a ROB tag allocation. Compared with the fixed three-channel dispatch it adds:
- generic channel count and payload width
- a selectable full-throughput or registered-ready mode
- illegal-select detection
- a stall performance counter

---
 rtl/dispatch_router.sv | 115 +++++++++++
 1 files changed

// File: rtl/dispatch_router.sv
// Single-entry dispatch stage: holds one renamed packet and steers it to exactly one
// of NUM_FU reservation-station channels, paired atomically with a ROB tag allocation.

module dispatch_lane #(
  parameter int DATA_W = 64
) (
  input  logic              hold_valid,
  input  logic              sel,
  input  logic              sel_ok,
  input  logic              rs_ready,
  input  logic [DATA_W-1:0] hold_data,
  output logic              rs_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic              lane_fire
);
  assign rs_valid  = hold_valid && sel && sel_ok;
  assign rs_data   = hold_data;
  assign lane_fire = rs_valid && rs_ready;
endmodule

module dispatch_router #(
  parameter int NUM_FU = 3,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int PIPE   = 1,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [NUM_FU-1:0]        fu_sel_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic [NUM_FU-1:0]        rs_valid_out,
  output logic [NUM_FU*DATA_W-1:0] rs_data_out,
  output logic [TAG_W-1:0]         rs_tag_out,
  input  logic [NUM_FU-1:0]        rs_ready_in,
  input  logic                     rob_alloc_ready,
  input  logic [TAG_W-1:0]         rob_alloc_tag,
  output logic                     rob_alloc_valid,
  input  logic                     flush,
  output logic                     err_illegal,
  output logic [CNT_W-1:0]         stall_cycles
);

  typedef struct packed {
    logic [NUM_FU-1:0] sel;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic              hold_valid;
  pkt_t              hold;
  logic              sel_ok;
  logic              fire;
  logic              accept;
  logic              legal;
  logic [NUM_FU-1:0] lane_fire;

  function automatic logic is_onehot(input logic [NUM_FU-1:0] v);
    return (v != '0) && ((v & (v - NUM_FU'(1))) == '0);
  endfunction

  // ROB back-pressure and flush gate every channel at once, keeping RS and ROB in lockstep
  assign sel_ok = rob_alloc_ready && !flush;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    dispatch_lane #(.DATA_W(DATA_W)) u_lane (
      .hold_valid(hold_valid),
      .sel       (hold.sel[g]),
      .sel_ok    (sel_ok),
      .rs_ready  (rs_ready_in[g]),
      .hold_data (hold.data),
      .rs_valid  (rs_valid_out[g]),
      .rs_data   (rs_data_out[g*DATA_W +: DATA_W]),
      .lane_fire (lane_fire[g])
    );
  end

  assign fire            = |lane_fire;
  assign rob_alloc_valid = fire;
  assign rs_tag_out      = rob_alloc_tag;

  // PIPE=0 breaks the downstream-ready to upstream-ready path at the cost of a bubble
  if (PIPE != 0) begin : g_pipe
    assign ready_in = !reset && !flush && (!hold_valid || fire);
  end else begin : g_nopipe
    assign ready_in = !reset && !flush && !hold_valid;
  end

  assign accept = valid_in && ready_in;
  assign legal  = is_onehot(fu_sel_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid   <= 1'b0;
      hold         <= '0;
      err_illegal  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      err_illegal <= accept && !legal;
      if (flush) begin
        hold_valid <= 1'b0;
      end else if (accept && legal) begin
        hold_valid <= 1'b1;
        hold.sel   <= fu_sel_in;
        hold.data  <= data_in;
      end else if (fire) begin
        hold_valid <= 1'b0;
      end
      if (hold_valid && !fire && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
